// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared types and constants for the framebuffer access arbiter
package fb_arb_pkg;
    typedef enum logic [1:0] {IDLE, DISP, WR, FORCE} fb_arb_state_t;
    localparam int STARVE_W = 8;
endpackage

// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter: display-priority arbiter for one single-port framebuffer SRAM with writer starvation guard
//   clk, reset                   clock, synchronous active-high reset
//   disp_req/addr -> disp_gnt    display read request and combinational accept
//   disp_rvalid/disp_rdata       read return, two cycles after disp_gnt
//   wr_req/addr/data -> wr_gnt   pixel write request and combinational accept
//   mem_en/we/addr/wdata         registered SRAM command, mem_rdata read return
//   starve_cnt                   saturating count of forced writer grants
module fb_access_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 8,
    parameter int WR_MAX_WAIT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                disp_req,
    input  logic [ADDR_W-1:0]   disp_addr,
    output logic                disp_gnt,
    output logic                disp_rvalid,
    output logic [DATA_W-1:0]   disp_rdata,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_gnt,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [STARVE_W-1:0] starve_cnt
);
    localparam int WAIT_W = $clog2(WR_MAX_WAIT);

    fb_arb_state_t       state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rvalid_q, rvalid_d;
    logic                force_wr;

    always_comb begin
        force_wr = !reset && wr_req && (wait_q == WAIT_W'(WR_MAX_WAIT - 1));
        disp_gnt = !reset && !force_wr && disp_req;
        wr_gnt   = !reset && (force_wr || (wr_req && !disp_req));
        state_d  = force_wr ? FORCE : disp_gnt ? DISP : wr_gnt ? WR : IDLE;
        // a dropped request or a grant both restart the wait window
        wait_d   = (wr_req && !wr_gnt) ? wait_q + 1'b1 : '0;
        starve_d = (force_wr && starve_q != '1) ? starve_q + 1'b1 : starve_q;
        addr_d   = disp_gnt ? disp_addr : wr_gnt ? wr_addr : addr_q;
        wdata_d  = wr_gnt ? wr_data : wdata_q;
        // second stage of the read pipe: state_q==DISP means the SRAM read is in flight
        rvalid_d = state_q == DISP;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            starve_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign mem_en      = state_q != IDLE;
    assign mem_we      = state_q == WR || state_q == FORCE;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign disp_rvalid = rvalid_q;
    assign disp_rdata  = rvalid_q ? mem_rdata : '0;
    assign starve_cnt  = starve_q;
endmodule

// File: tb/tb_fb_access_arbiter.sv
// tb_fb_access_arbiter: vector, directed and random checks of fb_access_arbiter against a behavioural model
module tb_fb_access_arbiter;
    logic        clk = 1'b0;
    logic        reset, disp_req, wr_req;
    logic [11:0] disp_addr, wr_addr, mem_addr;
    logic [7:0]  wr_data, mem_wdata, mem_rdata, disp_rdata, starve_cnt;
    logic        disp_gnt, disp_rvalid, wr_gnt, mem_en, mem_we;

    int n_chk = 0;
    int n_fail = 0;

    fb_access_arbiter #(.ADDR_W(12), .DATA_W(8), .WR_MAX_WAIT(16)) dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] sram   [4096];
    logic [7:0] shadow [4096];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else mem_rdata <= sram[mem_addr];
        end
    end

    // model state: pending-write age, forced-grant tally, expected SRAM command and read return
    int          waited, starve_m;
    logic        e_en, e_we, prev_dg;
    logic [11:0] e_addr;
    logic [7:0]  e_wdata, prev_rd;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic step(input logic r, input logic d, input logic [11:0] da,
                        input logic w, input logic [11:0] wa, input logic [7:0] wd,
                        output logic gd, output logic gw);
        logic f, egd, egw, nrv;
        logic [7:0] rd, nrd;
        reset = r; disp_req = d; disp_addr = da; wr_req = w; wr_addr = wa; wr_data = wd;
        #1;
        f   = !r && w && waited == 15;
        egw = !r && (f || (w && !d));
        egd = !r && !f && d;
        chk("disp_gnt", disp_gnt, egd);
        chk("wr_gnt", wr_gnt, egw);
        gd = disp_gnt;
        gw = wr_gnt;
        rd = shadow[da];
        if (egw) shadow[wa] = wd;
        if (r) begin
            waited = 0; starve_m = 0; e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0;
            nrv = 0; nrd = 0; prev_dg = 0; prev_rd = 0;
        end else begin
            waited = (w && !egw) ? waited + 1 : 0;
            if (f && starve_m < 255) starve_m++;
            e_en = egd || egw;
            e_we = egw;
            if (egd) e_addr = da;
            else if (egw) e_addr = wa;
            if (egw) e_wdata = wd;
            nrv = prev_dg; nrd = prev_rd;
            prev_dg = egd; prev_rd = rd;
        end
        @(posedge clk);
        #1;
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_we);
        chk("starve_cnt", starve_cnt, starve_m);
        chk("disp_rvalid", disp_rvalid, nrv);
        if (r || e_en) chk("mem_addr", mem_addr, e_addr);
        if (r || e_we) chk("mem_wdata", mem_wdata, e_wdata);
        if (nrv) chk("disp_rdata", disp_rdata, nrd);
        if (r) chk("disp_rdata_rst", disp_rdata, 0);
    endtask

    typedef struct {
        logic r, d; logic [11:0] da; logic w; logic [11:0] wa; logic [7:0] wd; logic gd, gw;
    } vec_t;

    initial begin
        vec_t tbl[12];
        logic gd, gw, pd, pw;
        logic [11:0] da, wa;
        logic [7:0] wd;
        for (int i = 0; i < 4096; i++) begin
            sram[i] = 8'($urandom);
            shadow[i] = sram[i];
        end
        waited = 0; starve_m = 0; prev_dg = 0; prev_rd = 0;
        tbl[0]  = '{1, 1, 12'h010, 1, 12'h020, 8'h11, 0, 0};
        tbl[1]  = '{1, 1, 12'h010, 1, 12'h020, 8'h11, 0, 0};
        tbl[2]  = '{1, 1, 12'h010, 1, 12'h020, 8'h11, 0, 0};
        tbl[3]  = '{0, 1, 12'h010, 0, 12'h000, 8'h00, 1, 0};
        tbl[4]  = '{0, 1, 12'h011, 0, 12'h000, 8'h00, 1, 0};
        tbl[5]  = '{0, 1, 12'h012, 0, 12'h000, 8'h00, 1, 0};
        tbl[6]  = '{0, 1, 12'h013, 0, 12'h000, 8'h00, 1, 0};
        tbl[7]  = '{0, 0, 12'h000, 0, 12'h000, 8'h00, 0, 0};
        tbl[8]  = '{0, 0, 12'h000, 1, 12'h020, 8'h5A, 0, 1};
        tbl[9]  = '{0, 1, 12'h020, 0, 12'h000, 8'h00, 1, 0};
        tbl[10] = '{0, 0, 12'h000, 0, 12'h000, 8'h00, 0, 0};
        tbl[11] = '{0, 0, 12'h000, 0, 12'h000, 8'h00, 0, 0};
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].d, tbl[i].da, tbl[i].w, tbl[i].wa, tbl[i].wd, gd, gw);
            chk("vec_gnt", {30'd0, gd, gw}, {30'd0, tbl[i].gd, tbl[i].gw});
            if (i == 3) chk("vec_addr", mem_addr, 12'h010);
            if (i == 8) chk("vec_we", mem_we, 1);
            if (i == 10) chk("vec_rd5a", disp_rdata, 8'h5A);
        end

        // contention: forced write every 16th cycle
        step(1, 0, 0, 0, 0, 0, gd, gw);
        for (int i = 0; i < 48; i++) begin
            step(0, 1, 12'(12'h100 + i), 1, 12'h200, 8'(i), gd, gw);
            chk("cont_pattern", {30'd0, gd, gw}, (i % 16 == 15) ? 32'd1 : 32'd2);
        end
        chk("cont_starve", starve_cnt, 3);

        // saturation after 300 forced grants
        step(1, 0, 0, 0, 0, 0, gd, gw);
        for (int i = 0; i < 300 * 16; i++) step(0, 1, 12'(i), 1, 12'h300, 8'(i), gd, gw);
        chk("sat_starve", starve_cnt, 255);

        // reset the cycle after a display grant discards the read
        step(1, 0, 0, 0, 0, 0, gd, gw);
        step(0, 1, 12'h030, 0, 0, 0, gd, gw);
        chk("midrst_gnt", gd, 1);
        step(1, 0, 0, 0, 0, 0, gd, gw);
        chk("midrst_rv0", disp_rvalid, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, gd, gw);
            chk("midrst_rv", disp_rvalid, 0);
        end

        // random traffic with held requests, cancels and occasional reset
        pd = 0; pw = 0; da = 0; wa = 0; wd = 0; gd = 0; gw = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!(pd && !gd) || $urandom_range(7) == 0) begin
                pd = 1'($urandom_range(1));
                da = 12'($urandom_range(15));
            end
            if (!(pw && !gw) || $urandom_range(7) == 0) begin
                pw = ($urandom_range(3) != 0);
                wa = 12'($urandom_range(15));
                wd = 8'($urandom);
            end
            step($urandom_range(99) == 0, pd, da, pw, wa, wd, gd, gw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
